// File: rtl/trail_gen.sv
// ---------------------------------------------------------------------------
// trail_gen
//
// Purpose:
//   Keeps the player trail used by the frame-snapshot stage and the VGA
//   picture generator. It is a circular buffer of DEPTH points (x, y, life).
//   On every frame tick while the game is running:
//     - each live point scrolls left by SCROLL_SPEED pixels, and
//     - a point that reaches the left edge is killed.
//   Every SPAWN_INTERVAL ticks a new point is written at (PLAYER_X,
//   player_y). It always overwrites the oldest slot, whether that slot is
//   alive or not.
//
// Optional feature (compile-time macro TRAIL_FADE_EN):
//   Defined   : live points also lose one unit of life every LIFE_DIV ticks.
//               A point whose life reaches 0 dies, and its x is set to 0.
//   Undefined : life stays at MAX_LIFE until the point scrolls off or is
//               overwritten. LIFE_DIV is ignored.
//
// Ports:
//   clk          in   game clock; all logic runs on the rising edge
//   rst_n        in   asynchronous active-low reset
//   tick         in   one-cycle frame-advance strobe
//   run          in   1 = playing, 0 = frozen (ticks are ignored)
//   clear        in   synchronous wipe; takes priority over tick
//   player_y     in   [8:0] current player y, sampled on spawn
//   trail_x      out  [DEPTH*10-1:0] packed x; entry i at [i*10 +: 10]
//   trail_y      out  [DEPTH*9-1:0]  packed y; entry i at [i*9 +: 9]
//   trail_life   out  [DEPTH*4-1:0]  packed life; 0 = dead / not drawn
//   wr_ptr       out  [5:0] next slot to be written
//   active_count out  [5:0] number of entries with life != 0
//                     (combinational, taken from the current registers)
// ---------------------------------------------------------------------------
module trail_gen #(
    parameter int DEPTH          = 41,
    parameter int MAX_LIFE       = 15,
    parameter int SPAWN_INTERVAL = 2,
    parameter int SCROLL_SPEED   = 4,
    parameter int PLAYER_X       = 100,
    parameter int LIFE_DIV       = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick,
    input  logic                 run,
    input  logic                 clear,
    input  logic [8:0]           player_y,
    output logic [DEPTH*10-1:0]  trail_x,
    output logic [DEPTH*9-1:0]   trail_y,
    output logic [DEPTH*4-1:0]   trail_life,
    output logic [5:0]           wr_ptr,
    output logic [5:0]           active_count
);

    // A counter that wraps at 1 would need zero bits; keep at least one bit.
    localparam int SCW = (SPAWN_INTERVAL > 1) ? $clog2(SPAWN_INTERVAL) : 1;

    localparam logic [9:0]     SPEED     = 10'(SCROLL_SPEED);
    localparam logic [9:0]     SPAWN_X   = 10'(PLAYER_X);
    localparam logic [3:0]     LIFE_INIT = 4'(MAX_LIFE);
    localparam logic [SCW-1:0] SPAWN_TOP = SCW'(SPAWN_INTERVAL - 1);
    localparam logic [5:0]     PTR_TOP   = 6'(DEPTH - 1);

    // ------------------------------------------------------------------
    // Shared control state
    // ------------------------------------------------------------------
    logic [5:0]     r_wr_ptr;
    logic [SCW-1:0] r_spawn_cnt;

    // Clear beats tick, so an advance happens only when clear is low.
    logic w_adv;
    logic w_spawn;

    assign w_adv   = tick & run & ~clear;
    assign w_spawn = w_adv & (r_spawn_cnt == '0);

`ifdef TRAIL_FADE_EN
    localparam int DVW = (LIFE_DIV > 1) ? $clog2(LIFE_DIV) : 1;
    localparam logic [DVW-1:0] DIV_TOP = DVW'(LIFE_DIV - 1);

    logic [DVW-1:0] r_div_cnt;
    logic           w_fade;

    // Life ages on the ticks where the divider sits at zero.
    assign w_fade = (r_div_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
        end else if (clear) begin
            r_div_cnt <= '0;
        end else if (w_adv) begin
            r_div_cnt <= (r_div_cnt == DIV_TOP) ? '0 : r_div_cnt + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_spawn_cnt <= '0;
        end else if (clear) begin
            r_wr_ptr    <= '0;
            r_spawn_cnt <= '0;
        end else if (w_adv) begin
            r_spawn_cnt <= (r_spawn_cnt == SPAWN_TOP) ? '0 : r_spawn_cnt + 1'b1;
            if (w_spawn) begin
                r_wr_ptr <= (r_wr_ptr == PTR_TOP) ? 6'd0 : r_wr_ptr + 6'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-entry storage and update. Each entry owns its registers, so
    // every entry can be updated in parallel on every tick.
    // ------------------------------------------------------------------
    logic [DEPTH-1:0] w_alive;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [9:0] r_x;
        logic [8:0] r_y;
        logic [3:0] r_life;
        logic [9:0] w_x_next;
        logic [3:0] w_life_next;
        logic       w_hit;

        // This slot is the spawn target on this tick.
        assign w_hit = w_spawn && (r_wr_ptr == 6'(gi));

        // Scroll/age result for a live entry. Dead entries keep their
        // value, which is always zero unless this slot is spawned.
        always_comb begin
            w_x_next    = r_x;
            w_life_next = r_life;
            if (r_life != 4'd0) begin
                if (r_x <= SPEED) begin
                    // Would cross the left edge: the point is removed.
                    w_x_next    = 10'd0;
                    w_life_next = 4'd0;
                end else begin
                    w_x_next = r_x - SPEED;
`ifdef TRAIL_FADE_EN
                    if (w_fade) begin
                        w_life_next = r_life - 4'd1;
                        // The last unit of life is used up: the point dies.
                        if (r_life == 4'd1) begin
                            w_x_next = 10'd0;
                        end
                    end
`endif
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_x    <= '0;
                r_y    <= '0;
                r_life <= '0;
            end else if (clear) begin
                r_x    <= '0;
                r_y    <= '0;
                r_life <= '0;
            end else if (w_adv) begin
                if (w_hit) begin
                    // A spawn replaces the scroll/age update for this slot.
                    r_x    <= SPAWN_X;
                    r_y    <= player_y;
                    r_life <= LIFE_INIT;
                end else begin
                    r_x    <= w_x_next;
                    r_life <= w_life_next;
                end
            end
        end

        assign w_alive[gi]           = (r_life != 4'd0);
        assign trail_x[gi*10 +: 10]  = r_x;
        assign trail_y[gi*9 +: 9]    = r_y;
        assign trail_life[gi*4 +: 4] = r_life;
    end

    // ------------------------------------------------------------------
    // Live-entry population count
    // ------------------------------------------------------------------
    logic [5:0] w_count;

    always_comb begin
        w_count = 6'd0;
        for (int i = 0; i < DEPTH; i++) begin
            w_count = w_count + 6'(w_alive[i]);
        end
    end

    assign active_count = w_count;
    assign wr_ptr       = r_wr_ptr;

endmodule
